dmem_access_unit: RTL

Parametrised data-memory access controller for the MEM stage of the pipelined RV32i/RV64i core. Sits between the EX/MEM buffer and a data cache with a multi-cycle `dmem_resp` handshake: it latches a load/store request, drives a byte-lane-aligned bus access, stalls the pipeline until the response, and returns the aligned, sign- or zero-extended load value to MEM/WB. Bus width, register width and address width are generic. Misaligned-access trapping is optional.

---
 rtl/dmem_access_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory access controller.
// Latches a load/store, drives a lane-aligned bus access with registered
// strobes, stalls the pipeline until dmem_resp, and returns the aligned,
// sign/zero-extended load value.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of silently aligning them).
module dmem_access_unit #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [XLEN-1:0]       ld_data,
    output logic [DATA_W/8-1:0]   rmask,
    output logic [DATA_W/8-1:0]   wmask,
    output logic                  misalign,
    output logic [ADDR_W-1:0]     dmem_address,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [DATA_W/8-1:0]   dmem_byte_enable,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_resp
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;

    // request decode
    logic [1:0]        sl;
    logic              uns;
    logic              legal;
    logic [2:0]        low_mask;
    logic              trap;
    logic [OFF_W-1:0]  off;
    logic [NB-1:0]     mask;
    logic              ok;
    logic              ill_pulse;
    logic [DATA_W-1:0] wdata_sh;

    // latched request
    logic              write_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        sl_q;
    logic              uns_q;
    logic              ld_valid_q;
    logic [XLEN-1:0]   ld_data_q;

    // load extraction
    logic [XLEN-1:0]   rsh;
    logic [XLEN-1:0]   keep;
    logic              sbit;
    logic [XLEN-1:0]   ext;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic              mis;
`endif

    // Decode size/legality, alignment handling, lane offset and byte mask
    always_comb begin
        sl       = req_funct3[1:0];
        uns      = req_funct3[2];
        legal    = 1'b1;
        if (uns && req_write)
            legal = 1'b0;
        if (sl == 2'd3 && (XLEN != 64 || uns))
            legal = 1'b0;
        if (sl == 2'd2 && uns && XLEN != 64)
            legal = 1'b0;
        low_mask = (3'b001 << sl) - 3'b001;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis      = |(req_addr[2:0] & low_mask);
        trap     = mis;
        off      = req_addr[OFF_W-1:0];
        misalign = req_valid & legal & mis;
`else
        // Low size bits are dropped so the access is naturally aligned.
        trap     = 1'b0;
        off      = req_addr[OFF_W-1:0] & ~OFF_W'(low_mask);
        misalign = 1'b0;
`endif
        for (int unsigned i = 0; i < NB; i++)
            mask[i] = (i >= 32'(off)) && (i < 32'(off) + (32'd1 << sl));
        wdata_sh  = DATA_W'(req_wdata) << {off, 3'b000};
        ok        = legal & ~trap;
        ill_pulse = (state == IDLE) & req_valid & ~legal;
    end

    assign stall    = req_valid & ok & (state != DONE);
    assign rmask    = (req_valid & ok & ~req_write) ? mask : '0;
    assign wmask    = (req_valid & ok &  req_write) ? mask : '0;
    assign ld_valid = ld_valid_q | ill_pulse;
    assign ld_data  = ill_pulse ? '0 : ld_data_q;

    // Shift the returned word down to the latched lane, then extend by size
    always_comb begin
        rsh = XLEN'(dmem_rdata >> {off_q, 3'b000});
        case (sl_q)
            2'd0:    begin keep = XLEN'(64'hFF);        sbit = rsh[7];      end
            2'd1:    begin keep = XLEN'(64'hFFFF);      sbit = rsh[15];     end
            2'd2:    begin keep = XLEN'(64'hFFFF_FFFF); sbit = rsh[31];     end
            default: begin keep = '1;                   sbit = rsh[XLEN-1]; end
        endcase
        ext = (rsh & keep) | ((sbit & ~uns_q) ? ~keep : '0);
    end

    // Access FSM with registered bus strobes and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            write_q          <= 1'b0;
            off_q            <= '0;
            sl_q             <= '0;
            uns_q            <= 1'b0;
            ld_valid_q       <= 1'b0;
            ld_data_q        <= '0;
            dmem_address     <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= '0;
            dmem_wdata       <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ill_pulse) begin
                        ld_data_q <= '0;
                    end else if (req_valid && ok) begin
                        state            <= BUSY;
                        write_q          <= req_write;
                        off_q            <= off;
                        sl_q             <= sl;
                        uns_q            <= uns;
                        dmem_address     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        dmem_read        <= ~req_write;
                        dmem_write       <= req_write;
                        dmem_byte_enable <= req_write ? mask : '0;
                        dmem_wdata       <= req_write ? wdata_sh : '0;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        state            <= DONE;
                        dmem_read        <= 1'b0;
                        dmem_write       <= 1'b0;
                        dmem_byte_enable <= '0;
                        if (!write_q) begin
                            ld_data_q  <= ext;
                            ld_valid_q <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
